mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 63 ++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and shared memory port signals of the arbiter
// slave is the arbiter's view, master is the surrounding core/memory view
interface mem_arbiter_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        err;

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
   );

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data masters,
// one outstanding transaction, data priority with a fetch starvation limit
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          resetn,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic       owner_i;
   logic [3:0] starve_cnt;
   logic       pick_i;

   assign pick_i = bus.imem_req && (!bus.dmem_req || starve_cnt == LIMIT);

   assign bus.imem_gnt    = state == REQ && owner_i && bus.mem_gnt;
   assign bus.dmem_gnt    = state == REQ && !owner_i && bus.mem_gnt;
   assign bus.imem_rvalid = state == WAIT && owner_i && bus.mem_rvalid;
   assign bus.dmem_rvalid = state == WAIT && !owner_i && bus.mem_rvalid;
   assign bus.imem_rdata  = bus.mem_rdata;
   assign bus.dmem_rdata  = bus.mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         owner_i       <= 1'b0;
         starve_cnt    <= '0;
         bus.err       <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         if (bus.mem_rvalid && state != WAIT) bus.err <= 1'b1;
         case (state)
            IDLE: if (bus.imem_req || bus.dmem_req) begin
               state         <= REQ;
               owner_i       <= pick_i;
               bus.mem_req   <= 1'b1;
               bus.mem_we    <= pick_i ? 1'b0 : bus.dmem_we;
               bus.mem_be    <= pick_i ? 4'b1111 : bus.dmem_be;
               bus.mem_addr  <= pick_i ? bus.imem_addr : bus.dmem_addr;
               bus.mem_wdata <= pick_i ? 32'h0 : bus.dmem_wdata;
            end
            // starve_cnt never exceeds LIMIT, so the compare doubles as saturation
            REQ: if (bus.mem_gnt) begin
               state       <= WAIT;
               bus.mem_req <= 1'b0;
               if (owner_i) starve_cnt <= '0;
               else if (bus.imem_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end
            WAIT: if (bus.mem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized core/memory traffic checked against a
// transaction-level model of arbitration, field capture and response routing
module tb_mem_arbiter;
   localparam int LIMIT = 3;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   bit          i_pend, d_pend, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   bit          txn_on, txn_gnted, txn_i, was_idle;
   bit          t_we;
   logic [3:0]  t_be;
   logic [31:0] t_addr, t_wdata;
   int          d_streak;
   string       order;

   task automatic model_reset();
      i_pend = 0; d_pend = 0; txn_on = 0; txn_gnted = 0; txn_i = 0;
      was_idle = 0; d_streak = 0;
   endtask

   task automatic drive_idle();
      bus.imem_req = 0; bus.imem_addr = 0;
      bus.dmem_req = 0; bus.dmem_we = 0; bus.dmem_be = 0; bus.dmem_addr = 0; bus.dmem_wdata = 0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
   endtask

   task automatic check_rst_vals();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_gnt", {bus.imem_gnt, bus.dmem_gnt}, 0);
      chk("rst_rvalid", {bus.imem_rvalid, bus.dmem_rvalid}, 0);
   endtask

   // one clock of traffic: probabilities in percent for new requests, mem_gnt, mem_rvalid
   task automatic step(input int p_req, input int p_gnt, input int p_rv);
      bit pi, pd, start, g_req, rv;
      logic [31:0] rd;
      @(negedge clk);
      pi = bus.imem_req;
      pd = bus.dmem_req;
      if (!txn_on) begin
         start = was_idle && (pi || pd);
         chk("mem_req_start", bus.mem_req, start);
         if (start) begin
            txn_i   = pi && (!pd || d_streak == LIMIT);
            t_addr  = txn_i ? i_addr : d_addr;
            t_we    = txn_i ? 1'b0 : d_we;
            t_be    = txn_i ? 4'b1111 : d_be;
            t_wdata = txn_i ? 32'h0 : d_wdata;
            if (order.len() < 8) order = {order, txn_i ? "I" : "D"};
            txn_on = 1; txn_gnted = 0;
         end
      end else chk("mem_req_busy", bus.mem_req, !txn_gnted);
      if (txn_on && !txn_gnted) begin
         chk("mem_addr", bus.mem_addr, t_addr);
         chk("mem_we", bus.mem_we, t_we);
         chk("mem_be", bus.mem_be, t_be);
         chk("mem_wdata", bus.mem_wdata, t_wdata);
      end
      if (!i_pend && $urandom_range(99) < p_req) begin
         i_pend = 1; i_addr = $urandom;
      end
      if (!d_pend && $urandom_range(99) < p_req) begin
         d_pend = 1; d_we = 1'($urandom); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      rd = $urandom;
      bus.imem_req = i_pend; bus.imem_addr = i_addr;
      bus.dmem_req = d_pend; bus.dmem_we = d_we; bus.dmem_be = d_be;
      bus.dmem_addr = d_addr; bus.dmem_wdata = d_wdata;
      bus.mem_gnt = $urandom_range(99) < p_gnt;
      bus.mem_rvalid = txn_on && txn_gnted && $urandom_range(99) < p_rv;
      bus.mem_rdata = rd;
      #1;
      g_req = txn_on && !txn_gnted && bus.mem_gnt;
      rv = txn_on && txn_gnted && bus.mem_rvalid;
      chk("imem_gnt", bus.imem_gnt, g_req && txn_i);
      chk("dmem_gnt", bus.dmem_gnt, g_req && !txn_i);
      chk("imem_rvalid", bus.imem_rvalid, rv && txn_i);
      chk("dmem_rvalid", bus.dmem_rvalid, rv && !txn_i);
      chk("imem_rdata", bus.imem_rdata, rd);
      chk("dmem_rdata", bus.dmem_rdata, rd);
      chk("err_clean", bus.err, 0);
      was_idle = !txn_on;
      if (g_req) begin
         txn_gnted = 1;
         if (txn_i) begin
            i_pend = 0; d_streak = 0;
         end else begin
            d_pend = 0;
            if (i_pend) d_streak = d_streak < LIMIT ? d_streak + 1 : LIMIT;
         end
      end else if (rv) txn_on = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      resetn = 0;
      model_reset();
      #1 check_rst_vals();
      @(negedge clk);
      resetn = 1;
   endtask

   initial begin
      drive_idle();
      order = "";
      do_reset();
      // saturated traffic with zero-wait memory exposes the starvation pattern
      for (int i = 0; i < 30; i++) step(100, 100, 100);
      chk("grant_order_DDDIDDDI", order == "DDDIDDDI", 1);
      for (int i = 0; i < 1500; i++) step(40, 50, 50);
      for (int i = 0; i < 300; i++) step(90, 25, 30);
      do_reset();
      for (int i = 0; i < 20 && !txn_gnted; i++) step(100, 100, 0);
      chk("reach_wait", txn_gnted, 1);
      @(posedge clk);
      #2;
      bus.mem_gnt = 1; bus.mem_rvalid = 0;
      resetn = 0;
      #1 check_rst_vals();
      bus.mem_rvalid = 1;
      #1 chk("rst_rvalid_blocked", {bus.imem_rvalid, bus.dmem_rvalid}, 0);
      @(negedge clk);
      drive_idle();
      model_reset();
      resetn = 1;
      @(negedge clk);
      bus.mem_rvalid = 1;
      #1 chk("late_rvalid_fwd", {bus.imem_rvalid, bus.dmem_rvalid}, 0);
      @(negedge clk);
      bus.mem_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("err_sticky", bus.err, 1);
         chk("err_idle_req", bus.mem_req, 0);
         @(negedge clk);
      end
      resetn = 0;
      #1 chk("err_cleared", bus.err, 0);
      @(negedge clk);
      resetn = 1;
      for (int i = 0; i < 300; i++) step(50, 60, 60);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
